// File: rtl/clint_timer.sv
// -----------------------------------------------------------------------------
// clint_timer
//
// Machine-level timer and software-interrupt source. Keeps the free-running
// 64-bit mtime counter (also exported to the CSR unit for TIME/TIMEH), holds
// the 64-bit mtimecmp compare value and the MSIP bit, and exposes all three as
// 32-bit memory-mapped registers on a simple valid/ready data bus.
//
// Register map (byte offsets, bits [1:0] of mem_addr ignored):
//   0x0000  MSIP            bit 0 only, other bits read 0
//   0x4000  MTIMECMP[31:0]
//   0x4004  MTIMECMP[63:32]
//   0xBFF8  MTIME[31:0]
//   0xBFFC  MTIME[63:32]
//   other   reads 0, writes ignored, response still given
//
// Build option:
//   CLINT_MSIP_EN  defined   -> MSIP register implemented, drives soft_irq
//                  undefined -> offset 0x0000 is unmapped, soft_irq tied 0
//
// Parameters:
//   TICK_DIV  clock cycles per mtime increment (>= 1)
//   ADDR_W    width of the decoded bus offset
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous, active-high reset
//   mem_valid  in   bus request
//   mem_we     in   1 = write, 0 = read
//   mem_addr   in   byte offset
//   mem_wdata  in   write data
//   mem_wstrb  in   byte enables for writes
//   mem_ready  out  one-cycle response strobe, one cycle after acceptance
//   mem_rdata  out  read data, valid while mem_ready = 1
//   mtime      out  current timer value
//   timer_irq  out  MTIP, registered (mtime >= mtimecmp)
//   soft_irq   out  MSIP bit 0
// -----------------------------------------------------------------------------
module clint_timer #(
  parameter int TICK_DIV = 1,
  parameter int ADDR_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic [63:0]       mtime,
  output logic              timer_irq,
  output logic              soft_irq
);

  // Prescaler width; a one-bit counter is kept even when TICK_DIV = 1 so the
  // terminal-count compare below stays uniform (it is then always true).
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  localparam logic [ADDR_W-1:0] OFF_MSIP     = ADDR_W'('h0000);
  localparam logic [ADDR_W-1:0] OFF_MTCMP_LO = ADDR_W'('h4000);
  localparam logic [ADDR_W-1:0] OFF_MTCMP_HI = ADDR_W'('h4004);
  localparam logic [ADDR_W-1:0] OFF_MTIME_LO = ADDR_W'('hBFF8);
  localparam logic [ADDR_W-1:0] OFF_MTIME_HI = ADDR_W'('hBFFC);
  localparam logic [ADDR_W-1:0] WORD_MASK    = ~ADDR_W'(3);

  // Bus FSM encoding
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  logic [0:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic [63:0]      mtimecmp;

  logic [ADDR_W-1:0] addr_word;
  logic              accept;
  logic              wr;
  logic              sel_mtcmp_lo;
  logic              sel_mtcmp_hi;
  logic              sel_mtime_lo;
  logic              sel_mtime_hi;
  logic [31:0]       rd_word;

  // Replace the enabled bytes of a 32-bit word with the write data.
  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  // Address decode. Masking rather than slicing keeps every address bit
  // in the expression while ignoring the byte-lane bits.
  assign addr_word    = mem_addr & WORD_MASK;
  assign sel_mtcmp_lo = (addr_word == OFF_MTCMP_LO);
  assign sel_mtcmp_hi = (addr_word == OFF_MTCMP_HI);
  assign sel_mtime_lo = (addr_word == OFF_MTIME_LO);
  assign sel_mtime_hi = (addr_word == OFF_MTIME_HI);

  // A request is only taken in IDLE; a valid held through RESP waits for
  // the next IDLE cycle, giving one access per two cycles at best.
  assign accept = mem_valid && (state == IDLE);
  assign wr     = accept && mem_we;

  // ---------------------------------------------------------------------------
  // MSIP (optional)
  // ---------------------------------------------------------------------------
`ifdef CLINT_MSIP_EN
  logic msip;
  logic sel_msip;

  assign sel_msip = (addr_word == OFF_MSIP);

  always_ff @(posedge clock) begin
    if (reset) begin
      msip <= 1'b0;
    end else if (wr && sel_msip && mem_wstrb[0]) begin
      msip <= mem_wdata[0];
    end
  end

  assign soft_irq = msip;
`else
  assign soft_irq = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read mux: sees the registers before any update at this edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_word = 32'h0;
`ifdef CLINT_MSIP_EN
    if (sel_msip) rd_word = {31'h0, msip};
`endif
    if (sel_mtcmp_lo) rd_word = mtimecmp[31:0];
    if (sel_mtcmp_hi) rd_word = mtimecmp[63:32];
    if (sel_mtime_lo) rd_word = mtime[31:0];
    if (sel_mtime_hi) rd_word = mtime[63:32];
  end

  // ---------------------------------------------------------------------------
  // mtime and prescaler
  // ---------------------------------------------------------------------------
  // A bus write to either half takes the place of the tick for that cycle and
  // restarts the prescaler; the untouched half keeps its value (no carry).
  always_ff @(posedge clock) begin
    if (reset) begin
      mtime   <= 64'h0;
      div_cnt <= '0;
    end else if (wr && sel_mtime_lo) begin
      mtime[31:0] <= byte_merge(mtime[31:0], mem_wdata, mem_wstrb);
      div_cnt     <= '0;
    end else if (wr && sel_mtime_hi) begin
      mtime[63:32] <= byte_merge(mtime[63:32], mem_wdata, mem_wstrb);
      div_cnt      <= '0;
    end else if (div_cnt == DIV_LAST) begin
      // Natural 64-bit wrap from all-ones to zero.
      mtime   <= mtime + 64'd1;
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // mtimecmp
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (wr && sel_mtcmp_lo) begin
      mtimecmp[31:0] <= byte_merge(mtimecmp[31:0], mem_wdata, mem_wstrb);
    end else if (wr && sel_mtcmp_hi) begin
      mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], mem_wdata, mem_wstrb);
    end
  end

  // ---------------------------------------------------------------------------
  // Timer interrupt: registered unsigned compare of the current registers,
  // so it trails any change of mtime or mtimecmp by one cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_irq <= 1'b0;
    end else begin
      timer_irq <= (mtime >= mtimecmp);
    end
  end

  // ---------------------------------------------------------------------------
  // Bus FSM and read-data capture
  // ---------------------------------------------------------------------------
  // Reset wins over an acceptance in the same cycle, so an aborted request
  // neither writes (register blocks above check reset first) nor responds.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mem_rdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_valid) begin
            mem_rdata <= rd_word;
            state     <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_ready = (state == RESP);

endmodule

// File: tb/tb_clint_timer.sv
// -----------------------------------------------------------------------------
// tb_clint_timer
//
// Self-checking bench for clint_timer. A main instance (TICK_DIV = 4) takes
// directed and random bus traffic; an auxiliary instance (TICK_DIV = 1) sits
// idle on the bus and only counts. Expected behaviour comes from a reference
// model in which mtime is a base value plus elapsed cycles / TICK_DIV.
// Honours CLINT_MSIP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_clint_timer;

  localparam int TDIV = 4;
`ifdef CLINT_MSIP_EN
  localparam bit MSIP_EN = 1'b1;
`else
  localparam bit MSIP_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [63:0] mtime;
  logic        timer_irq;
  logic        soft_irq;

  logic        a_valid;
  logic        a_we;
  logic [15:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_wstrb;
  logic        a_ready;
  logic [31:0] a_rdata;
  logic [63:0] a_mtime;
  logic        a_irq;
  logic        a_soft;

  always #5 clock = ~clock;

  clint_timer #(.TICK_DIV(TDIV), .ADDR_W(16)) dut (
    .clock(clock), .reset(reset),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mtime(mtime), .timer_irq(timer_irq), .soft_irq(soft_irq)
  );

  clint_timer #(.TICK_DIV(1), .ADDR_W(16)) dut_aux (
    .clock(clock), .reset(reset),
    .mem_valid(a_valid), .mem_we(a_we), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_wstrb(a_wstrb),
    .mem_ready(a_ready), .mem_rdata(a_rdata),
    .mtime(a_mtime), .timer_irq(a_irq), .soft_irq(a_soft)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_base;   // mtime value at the last reset or mtime write
  logic [63:0] m_cyc;    // clock edges since then
  logic [63:0] m_cmp;
  logic        m_msip;
  logic        m_irq;
  logic        m_ready;  // a response is showing this cycle
  logic [31:0] m_rdata;
  logic [63:0] a_cnt;

  function automatic logic [63:0] m_now();
    return m_base + m_cyc / 64'(TDIV);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] w);
    logic [63:0] t;
    t = m_now();
    case (w)
      16'h0000: return MSIP_EN ? {31'h0, m_msip} : 32'h0;
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return t[31:0];
      16'hBFFC: return t[63:32];
      default:  return 32'h0;
    endcase
  endfunction

  // One clock edge: advance the model from the inputs now on the bus, then
  // compare every output shortly after the edge.
  task automatic step();
    logic [63:0] cur;
    logic [15:0] w;
    logic        acc;
    logic        wr;
    logic        nirq;
    logic [31:0] rd;
    if (reset) begin
      m_base = 64'h0; m_cyc = 64'h0; m_cmp = '1; m_msip = 1'b0;
      m_irq = 1'b0; m_ready = 1'b0; m_rdata = 32'h0; a_cnt = 64'h0;
    end else begin
      cur  = m_now();
      w    = mem_addr & 16'hFFFC;
      acc  = mem_valid && !m_ready;
      wr   = acc && mem_we;
      nirq = (cur >= m_cmp);
      rd   = m_read(w);
      if (wr && w == 16'hBFF8) begin
        m_base = {cur[63:32], merge(cur[31:0], mem_wdata, mem_wstrb)};
        m_cyc  = 64'h0;
      end else if (wr && w == 16'hBFFC) begin
        m_base = {merge(cur[63:32], mem_wdata, mem_wstrb), cur[31:0]};
        m_cyc  = 64'h0;
      end else begin
        m_cyc = m_cyc + 64'd1;
      end
      if (wr && w == 16'h4000) m_cmp[31:0]  = merge(m_cmp[31:0], mem_wdata, mem_wstrb);
      if (wr && w == 16'h4004) m_cmp[63:32] = merge(m_cmp[63:32], mem_wdata, mem_wstrb);
      if (wr && w == 16'h0000 && mem_wstrb[0]) m_msip = mem_wdata[0];
      if (acc) m_rdata = rd;
      m_irq   = nirq;
      m_ready = acc;
      a_cnt   = a_cnt + 64'd1;
    end
    @(posedge clock);
    #1;
    chk("mtime", mtime, m_now());
    chk("timer_irq", timer_irq, m_irq);
    chk("soft_irq", soft_irq, MSIP_EN & m_msip);
    chk("mem_ready", mem_ready, m_ready);
    if (m_ready) chk("mem_rdata", mem_rdata, m_rdata);
    chk("aux_mtime", a_mtime, a_cnt);
    chk("aux_ready", a_ready, 1'b0);
    chk("aux_rdata", a_rdata, 32'h0);
    chk("aux_irq", a_irq, 1'b0);
    chk("aux_soft", a_soft, 1'b0);
  endtask

  // Present a request for one edge; on return the response cycle is showing.
  task automatic bus_req(input logic we, input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    mem_valid = 1'b1; mem_we = we; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    step();
    mem_valid = 1'b0; mem_we = 1'b0;
    chk("ack", mem_ready, 1'b1);
  endtask

  task automatic bus(input logic we, input logic [15:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    bus_req(we, a, d, s);
    step();
    chk("ack_end", mem_ready, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hi_exp;
    logic [15:0] ra;
    int          waited;
    int          pulses;

    reset = 1'b1; mem_valid = 1'b0; mem_we = 1'b0; mem_addr = 16'h0;
    mem_wdata = 32'h0; mem_wstrb = 4'h0;
    a_valid = 1'b0; a_we = 1'b0; a_addr = 16'h0; a_wdata = 32'h0; a_wstrb = 4'h0;

    // Reset state
    step(); step();
    chk("rst_mtime", mtime, 64'h0);
    chk("rst_irq", timer_irq, 1'b0);
    chk("rst_ready", mem_ready, 1'b0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_soft", soft_irq, 1'b0);
    reset = 1'b0;

    // Free running: TICK_DIV=1 after 10 edges, TICK_DIV=4 after 12 edges
    for (int i = 0; i < 10; i++) step();
    chk("div1_mtime10", a_mtime, 64'd10);
    chk("div1_irq", a_irq, 1'b0);
    step(); step();
    chk("div4_mtime3", mtime, 64'd3);

    // Compare and interrupt timing
    bus(1'b1, 16'hBFF8, 32'h0, 4'hF);
    bus(1'b1, 16'h4000, 32'd5, 4'hF);
    bus(1'b1, 16'h4004, 32'd0, 4'hF);
    waited = 0;
    while (mtime != 64'd5 && waited < 200) begin
      step();
      waited++;
    end
    chk("reach5_timeout", (waited < 200), 1'b1);
    chk("irq_lag_low", timer_irq, 1'b0);
    step();
    chk("irq_rise", timer_irq, 1'b1);
    bus_req(1'b1, 16'h4004, 32'd1, 4'hF);
    chk("irq_hold_at_write", timer_irq, 1'b1);
    step();
    chk("irq_fall", timer_irq, 1'b0);

    // Wrap and byte-masked write
    bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    bus_req(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    chk("all_ones", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    step(); step(); step();
    chk("all_ones_hold", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    chk("wrap_zero", mtime, 64'h0);
    bus(1'b1, 16'hBFF8, 32'h0000_AB00, 4'b0010);
    chk("byte1", mtime[15:8], 8'hAB);
    chk("byte_hi_untouched", mtime[63:32], 32'h0);

    // Reads
    hi_exp = m_now() >> 32;
    bus_req(1'b0, 16'hBFFC, 32'h0, 4'h0);
    chk("rd_mtime_hi", mem_rdata, hi_exp);
    step();
    bus_req(1'b0, 16'h1234, 32'h0, 4'h0);
    chk("rd_unmapped", mem_rdata, 32'h0);
    step();
    bus(1'b1, 16'h0000, 32'h1, 4'hF);
    chk("soft_after_write", soft_irq, MSIP_EN);
    bus_req(1'b0, 16'h0000, 32'h0, 4'h0);
    chk("rd_msip", mem_rdata, 32'(MSIP_EN));
    step();

    // Held valid: responses every other cycle
    mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 16'hBFF8;
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("held_pattern", mem_ready, (k % 2) == 1);
      if (mem_ready) pulses++;
    end
    chk("held_pulses", pulses, 3);
    mem_valid = 1'b0;
    step();

    // Reset coinciding with acceptance: no response, no write
    mem_valid = 1'b1; mem_we = 1'b1; mem_addr = 16'h0000; mem_wdata = 32'h1;
    mem_wstrb = 4'hF; reset = 1'b1;
    step();
    reset = 1'b0; mem_valid = 1'b0;
    chk("abort_soft", soft_irq, 1'b0);
    chk("abort_ready", mem_ready, 1'b0);
    step();
    chk("abort_ready2", mem_ready, 1'b0);

    // Reset in the response cycle after an MSIP write
    bus_req(1'b1, 16'h0000, 32'h1, 4'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("resp_rst_soft", soft_irq, 1'b0);
    chk("resp_rst_ready", mem_ready, 1'b0);
    chk("resp_rst_mtime", mtime, 64'h0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 6))
        0: ra = 16'h0000;
        1: ra = 16'h4000;
        2: ra = 16'h4004;
        3: ra = 16'hBFF8;
        4: ra = 16'hBFFC;
        5: ra = 16'h1234;
        default: ra = 16'($urandom);
      endcase
      mem_valid = ($urandom_range(0, 1) == 1);
      mem_we    = ($urandom_range(0, 1) == 1);
      mem_addr  = ra | 16'($urandom_range(0, 3));
      mem_wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                              : $urandom;
      mem_wstrb = 4'($urandom);
      reset     = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; mem_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
